// File: rtl/cpu_mem_pkg.sv
// Shared state/owner encodings and width defaults for the CPU memory arbiter.
package cpu_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports; data has priority unless fetch has
// been passed over STARVE_MAX times in a row.
module mem_arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic idle,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved    = inst_req && (starve_q == CNT_W'(STARVE_MAX));
  assign grant_data = idle && data_req && !starved;
  assign grant_inst = idle && inst_req && !grant_data;

  // Counts data grants made while a fetch waits; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (grant_inst) begin
      starve_q <= '0;
    end else if (grant_data && inst_req && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges CPU fetch and load/store ports onto one memory port, one transaction
// in flight: IDLE accepts, REQ holds mem_req until gnt, RESP waits rvalid, DONE pulses.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                proto_err
);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic                idle;
  logic                grant_inst;
  logic                grant_data;
  logic                mem_req_q;
  logic                mem_wr_q;
  logic [DATA_W/8-1:0] mem_wstrb_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                inst_data_ok_q;
  logic                data_data_ok_q;
  logic                proto_err_q;

  // Gating with resetn keeps addr_ok low while reset is held.
  assign idle = resetn && (state_q == IDLE);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .resetn    (resetn),
    .idle      (idle),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      mem_req_q      <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_wstrb_q    <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      if (mem_rvalid && (state_q != RESP)) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            owner_q     <= OWN_DATA;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= data_wr;
            mem_wstrb_q <= data_wstrb;
            mem_addr_q  <= data_addr;
            mem_wdata_q <= data_wdata;
            state_q     <= REQ;
          end else if (grant_inst) begin
            owner_q     <= OWN_INST;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= inst_addr;
            mem_wdata_q <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state_q <= DONE;
            if (owner_q == OWN_INST) begin
              inst_data_ok_q <= 1'b1;
              if (!mem_wr_q) inst_rdata_q <= mem_rdata;
            end else begin
              data_data_ok_q <= 1'b1;
              if (!mem_wr_q) data_rdata_q <= mem_rdata;
            end
          end
        end
        DONE: begin
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign proto_err    = proto_err_q;

endmodule
